gates_reduce_pipe: RTL

//  Parametrised, registered successor of the 4-input gate block. Computes AND/NAND/OR/NOR/XOR/XNOR

---
 rtl/gates_reduce_pipe_if.sv | 26 ++
 rtl/gates_reduce_pipe.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/gates_reduce_pipe_if.sv
// Operand-in / result-out handshake bundle for gates_reduce_pipe.
// The producer/consumer side uses master; the block itself uses slave.
interface gates_reduce_pipe_if #(
    parameter int WIDTH = 4
);
    localparam int POPW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a;
    logic             a_valid;
    logic             a_ready;
    logic [5:0]       y;
    logic [POPW-1:0]  y_pop;
    logic [WIDTH-1:0] y_src;
    logic             y_valid;
    logic             y_ready;

    modport master (
        output a, a_valid, y_ready,
        input  a_ready, y, y_pop, y_src, y_valid
    );

    modport slave (
        input  a, a_valid, y_ready,
        output a_ready, y, y_pop, y_src, y_valid
    );
endinterface

// File: rtl/gates_reduce_pipe.sv
// Registered gate-reduction and popcount block with a one-entry output slot
// and a self-driven SWEEP mode that walks every operand value once.
module gates_reduce_pipe #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  mode,
    input  logic                  start,
    gates_reduce_pipe_if.slave    bus,
    output logic                  busy,
    output logic                  done
);
    localparam int POPW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] cnt_r;
    logic [5:0]       y_r;
    logic [POPW-1:0]  y_pop_r;
    logic [WIDTH-1:0] y_src_r;
    logic             y_valid_r;
    logic             busy_r;
    logic             done_r;

    logic             free_s;
    logic             load_s;
    logic             a_ready_s;
    logic             sweep_go_s;
    logic [WIDTH-1:0] op_s;

    // Bit order {and, nand, or, nor, xor, xnor}, MSB first.
    function automatic logic [5:0] reduce6(input logic [WIDTH-1:0] v);
        return {&v, ~&v, |v, ~|v, ^v, ~^v};
    endfunction

    function automatic logic [POPW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [POPW-1:0] sum;
        sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum = sum + POPW'(v[i]);
        end
        return sum;
    endfunction

    // Slot availability, operand source selection and load decision per state.
    always_comb begin
        free_s     = ~y_valid_r | bus.y_ready;
        sweep_go_s = 1'b0;
        a_ready_s  = 1'b0;
        load_s     = 1'b0;
        op_s       = bus.a;
        case (state_r)
            IDLE: begin
                // The cycle that launches a sweep takes no external operand.
                sweep_go_s = start & mode;
                a_ready_s  = free_s & ~sweep_go_s;
                load_s     = bus.a_valid & a_ready_s;
                op_s       = bus.a;
            end
            SWEEP: begin
                load_s = free_s;
                op_s   = cnt_r;
            end
            DRAIN: begin
                load_s = 1'b0;
                op_s   = cnt_r;
            end
            default: begin
                load_s = 1'b0;
                op_s   = bus.a;
            end
        endcase
    end

    // One-entry result register: holds under backpressure, replaces on load.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            y_r       <= 6'd0;
            y_pop_r   <= '0;
            y_src_r   <= '0;
            y_valid_r <= 1'b0;
        end else begin
            y_valid_r <= load_s | (y_valid_r & ~bus.y_ready);
            if (load_s) begin
                y_r     <= reduce6(op_s);
                y_pop_r <= popcount(op_s);
                y_src_r <= op_s;
            end
        end
    end

    // Sweep controller with registered busy and one-cycle done pulse.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (sweep_go_s) begin
                        state_r <= SWEEP;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                    end
                end
                SWEEP: begin
                    // Counter parks at its maximum instead of wrapping.
                    if (free_s) begin
                        if (cnt_r == CNT_MAX) begin
                            state_r <= DRAIN;
                        end else begin
                            cnt_r <= cnt_r + WIDTH'(1'b1);
                        end
                    end
                end
                DRAIN: begin
                    if (y_valid_r && bus.y_ready) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a_ready = a_ready_s;
    assign bus.y       = y_r;
    assign bus.y_pop   = y_pop_r;
    assign bus.y_src   = y_src_r;
    assign bus.y_valid = y_valid_r;
    assign busy        = busy_r;
    assign done        = done_r;
endmodule
